// File: rtl/shake_block_padder_pkg.sv
// Shared constants and types for the SHAKE/SHA3 block padder.
// Build option: define KECCAK_PAD_SHA3_EN to select SHA3 domain padding (0x06)
// instead of SHAKE domain padding (0x1F).
package shake_block_padder_pkg;

  // Rate in 32-bit words for the two SHAKE variants.
  localparam int RATE_WORDS_SHAKE128 = 42;
  localparam int RATE_WORDS_SHAKE256 = 34;

`ifdef KECCAK_PAD_SHA3_EN
  localparam logic [7:0] DOMAIN_BYTE = 8'h06;
`else
  localparam logic [7:0] DOMAIN_BYTE = 8'h1F;
`endif

  // Last bit of multi-rate padding, ORed into the final byte of the block.
  localparam logic [7:0] FINAL_BIT = 8'h80;

  typedef enum logic [1:0] {
    ABSORB,
    PAD,
    FULL_LAST
  } phase_e;

endpackage

// File: rtl/shake_block_padder_if.sv
// Message-in / block-out bus between the message source, the padder and the
// Keccak-f permutation. The master side drives the message and the ack.
interface shake_block_padder_if #(
  parameter int RATE_WORDS = 42
);
  logic [31:0]              in;
  logic                     in_ready;
  logic                     is_last;
  logic [1:0]               byte_num;
  logic                     f_ack;
  logic                     buffer_full;
  logic [32*RATE_WORDS-1:0] out;
  logic                     out_ready;
  logic                     last_block;

  modport master (
    output in, in_ready, is_last, byte_num, f_ack,
    input  buffer_full, out, out_ready, last_block
  );

  modport slave (
    input  in, in_ready, is_last, byte_num, f_ack,
    output buffer_full, out, out_ready, last_block
  );
endinterface

// File: rtl/shake_block_padder_pad_word.sv
// Pads the final, partial message word: the domain byte directly follows the
// last valid message byte and the remaining low bytes are zero.
module keccak_pad_word (
  input  logic [31:0] word_i,
  input  logic [1:0]  byte_num_i,
  input  logic [7:0]  domain_i,
  output logic [31:0] word_o
);

  // Select how many leading message bytes survive, then append the domain byte.
  always_comb begin
    // NOTE: word_o gets a default before the case so no latch can be inferred.
    word_o = '0;
    unique case (byte_num_i)
      2'd0: word_o = {domain_i, 24'h0};
      2'd1: word_o = {word_i[31:24], domain_i, 16'h0};
      2'd2: word_o = {word_i[31:16], domain_i, 8'h0};
      2'd3: word_o = {word_i[31:8], domain_i};
      default: word_o = '0;
    endcase
  end

endmodule

// File: rtl/shake_block_padder.sv
// Sequential SHAKE/SHA3 message padder: shifts 32-bit big-endian words into a
// rate-sized block, pads after the final partial word, and holds each full
// block until the permutation acks it.
// Build option: KECCAK_PAD_SHA3_EN selects the SHA3 domain byte.
module shake_block_padder
  import shake_block_padder_pkg::*;
#(
  parameter int RATE_WORDS = RATE_WORDS_SHAKE128
) (
  input  logic                 clk,
  input  logic                 reset,
  shake_block_padder_if.slave  bus
);

  localparam int CW = $clog2(RATE_WORDS + 1);
  localparam int BW = 32 * RATE_WORDS;
  localparam logic [CW-1:0] CNT_FULL = CW'(RATE_WORDS);
  localparam logic [CW-1:0] CNT_LAST = CW'(RATE_WORDS - 1);

  logic [BW-1:0] out_q, out_d;
  logic [CW-1:0] cnt_q, cnt_d;
  phase_e        phase_q, phase_d;

  logic          full;
  logic          last_slot;
  logic          accept;
  logic          pad_shift;
  logic [31:0]   padded_word;
  logic [31:0]   shift_word;

  assign full      = (cnt_q == CNT_FULL);
  assign last_slot = (cnt_q == CNT_LAST);
  assign accept    = bus.in_ready & ~full & (phase_q == ABSORB);
  assign pad_shift = (phase_q == PAD) & ~full;

  keccak_pad_word u_pad_word (
    .word_i     (bus.in),
    .byte_num_i (bus.byte_num),
    .domain_i   (DOMAIN_BYTE),
    .word_o     (padded_word)
  );

  // Next-state logic: pick the word to shift in, advance the counter and phase.
  always_comb begin
    out_d      = out_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    shift_word = '0;

    if (accept) begin
      shift_word = bus.is_last ? padded_word : bus.in;
      if (bus.is_last && last_slot) begin
        shift_word[7:0] = shift_word[7:0] | FINAL_BIT;
      end
    end else if (pad_shift) begin
      shift_word = last_slot ? {24'h0, FINAL_BIT} : 32'h0;
    end

    if (accept || pad_shift) begin
      out_d = {out_q[BW-33:0], shift_word};
      cnt_d = cnt_q + CW'(1);
    end

    // The permutation has taken the block; content stays, counter restarts.
    if (full && bus.f_ack) begin
      cnt_d = '0;
    end

    unique case (phase_q)
      ABSORB:    if (accept && bus.is_last) phase_d = last_slot ? FULL_LAST : PAD;
      PAD:       if (pad_shift && last_slot) phase_d = FULL_LAST;
      FULL_LAST: if (full && bus.f_ack) phase_d = ABSORB;
      default:   phase_d = ABSORB;
    endcase
  end

  // State registers with asynchronous active-high clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the block buffer is cleared as well, since out is visible and must read 0 after reset.
      out_q   <= '0;
      cnt_q   <= '0;
      phase_q <= ABSORB;
    end else begin
      // NOTE: non-blocking assignments so all registers update together at the edge.
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign bus.out         = out_q;
  assign bus.buffer_full = full;
  assign bus.out_ready   = full;
  assign bus.last_block  = (phase_q == FULL_LAST);

endmodule

// File: tb/tb_shake_block_padder.sv
// Self-checking bench for shake_block_padder. The reference model builds the
// padded message as a byte list (message, domain byte, zero fill to a whole
// number of blocks, 0x80 ORed into the last byte) and compares each block.
module tb_shake_block_padder;

  localparam int RW = 42;
`ifdef KECCAK_PAD_SHA3_EN
  localparam logic [7:0] D = 8'h06;
`else
  localparam logic [7:0] D = 8'h1F;
`endif

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] msg_q[$];
  logic [7:0] pad_q[$];

  shake_block_padder_if #(.RATE_WORDS(RW)) bus ();

  shake_block_padder #(.RATE_WORDS(RW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dut_word(input int k);
    return bus.out[32*(RW-1-k) +: 32];
  endfunction

  function automatic logic [31:0] exp_word(input int b, input int k);
    int idx;
    idx = (b * RW + k) * 4;
    return {pad_q[idx], pad_q[idx+1], pad_q[idx+2], pad_q[idx+3]};
  endfunction

  // Send msg_q as one message, acking and checking every block it produces.
  task automatic run_message(input bit bubbles);
    int nbytes, nwords, nblocks, slot;
    int wi, blk, cyc, last_cyc, bad;
    bit prev_full, drove, done;
    logic [7:0] b [4];
    nbytes   = msg_q.size();
    nwords   = nbytes / 4 + 1;
    wi = 0; blk = 0; cyc = 0; last_cyc = -1;
    prev_full = 1'b0; drove = 1'b0; done = 1'b0;

    pad_q = {};
    foreach (msg_q[i]) pad_q.push_back(msg_q[i]);
    pad_q.push_back(D);
    while (pad_q.size() % (4 * RW) != 0) pad_q.push_back(8'h00);
    pad_q[pad_q.size()-1] = pad_q[pad_q.size()-1] | 8'h80;
    nblocks = pad_q.size() / (4 * RW);
    slot    = (nwords - 1) % RW;

    while (!done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (drove && !prev_full) begin
        wi++;
        if (wi == nwords) last_cyc = cyc;
      end
      bus.f_ack = 1'b0;
      prev_full = bus.buffer_full;

      if (bus.buffer_full) begin
        bad = -1;
        for (int k = 0; k < RW; k++)
          if (bad < 0 && dut_word(k) !== exp_word(blk, k)) bad = k;
        checks++;
        if (bad >= 0) begin
          errors++;
          $display("FAIL block_content blk=%0d word=%0d: got %h expected %h",
                   blk, bad, dut_word(bad), exp_word(blk, bad));
        end
        checks++;
        if (bus.last_block !== (blk == nblocks - 1)) begin
          errors++;
          $display("FAIL last_block blk=%0d: got %b expected %b",
                   blk, bus.last_block, (blk == nblocks - 1));
        end
        checks++;
        if (bus.out_ready !== 1'b1) begin
          errors++;
          $display("FAIL out_ready blk=%0d: got %b expected 1", blk, bus.out_ready);
        end
        if (blk == nblocks - 1) begin
          checks++;
          if (cyc - last_cyc != RW - slot - 1) begin
            errors++;
            $display("FAIL pad_latency: got %0d cycles expected %0d",
                     cyc - last_cyc, RW - slot - 1);
          end
          done = 1'b1;
        end
        bus.f_ack = 1'b1;
        blk++;
      end

      if (wi < nwords && !(bubbles && $urandom_range(3) == 0)) begin
        for (int j = 0; j < 4; j++)
          b[j] = (4*wi + j < nbytes) ? msg_q[4*wi + j] : 8'($urandom);
        bus.in       = {b[0], b[1], b[2], b[3]};
        bus.in_ready = 1'b1;
        bus.is_last  = (wi == nwords - 1);
        bus.byte_num = (wi == nwords - 1) ? 2'(nbytes % 4) : 2'($urandom);
      end else begin
        bus.in       = $urandom;
        bus.in_ready = 1'b0;
        bus.is_last  = 1'($urandom);
        bus.byte_num = 2'($urandom);
      end
      drove = bus.in_ready;
    end

    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d blocks expected %0d", blk, nblocks);
    end
    @(negedge clk);
    bus.f_ack    = 1'b0;
    bus.in_ready = 1'b0;
    checks++;
    if (bus.buffer_full !== 1'b0 || bus.last_block !== 1'b0) begin
      errors++;
      $display("FAIL after_ack: got full=%b last=%b expected 0 0",
               bus.buffer_full, bus.last_block);
    end
  endtask

  task automatic fill_random(input int n);
    msg_q = {};
    for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in = '0; bus.in_ready = 1'b0; bus.is_last = 1'b0;
    bus.byte_num = '0; bus.f_ack = 1'b0;
    #1;
    checks++;
    if (bus.out !== '0) begin errors++; $display("FAIL reset_out: got %h expected 0", bus.out); end
    checks++;
    if (bus.buffer_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", bus.buffer_full); end
    checks++;
    if (bus.out_ready !== 1'b0) begin errors++; $display("FAIL reset_out_ready: got %b expected 0", bus.out_ready); end
    checks++;
    if (bus.last_block !== 1'b0) begin errors++; $display("FAIL reset_last_block: got %b expected 0", bus.last_block); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_empty();
    msg_q = {};
    run_message(1'b0);
    checks++;
    if (dut_word(0) !== {D, 24'h0}) begin errors++; $display("FAIL empty_word0: got %h expected %h", dut_word(0), {D, 24'h0}); end
    checks++;
    if (dut_word(RW-1) !== 32'h80) begin errors++; $display("FAIL empty_word41: got %h expected 00000080", dut_word(RW-1)); end
  endtask

  task automatic test_full_last_word();
    fill_random(4 * (RW - 1));
    msg_q.push_back(8'h11); msg_q.push_back(8'h22); msg_q.push_back(8'h33);
    run_message(1'b0);
    checks++;
    if (dut_word(RW-1) !== {24'h112233, D | 8'h80})
      begin errors++; $display("FAIL last_slot_word: got %h expected %h", dut_word(RW-1), {24'h112233, D | 8'h80}); end
  endtask

  task automatic test_back_to_back();
    fill_random(4 * RW);
    msg_q.push_back(8'hAA); msg_q.push_back(8'hBB);
    run_message(1'b0);
    checks++;
    if (dut_word(0) !== {16'hAABB, D, 8'h00})
      begin errors++; $display("FAIL b2b_word0: got %h expected %h", dut_word(0), {16'hAABB, D, 8'h00}); end
    checks++;
    if (dut_word(RW-1) !== 32'h80) begin errors++; $display("FAIL b2b_word41: got %h expected 00000080", dut_word(RW-1)); end
  endtask

  task automatic test_domain();
    msg_q = {};
    msg_q.push_back(8'hAA);
    run_message(1'b0);
    checks++;
    if (dut_word(0) !== {8'hAA, D, 16'h0})
      begin errors++; $display("FAIL domain_word: got %h expected %h", dut_word(0), {8'hAA, D, 16'h0}); end
  endtask

  task automatic test_random();
    for (int m = 0; m < 8; m++) begin
      fill_random($urandom_range(0, 400));
      run_message(1'b1);
    end
  endtask

  task automatic test_reset_mid_pad();
    @(negedge clk);
    bus.in = $urandom; bus.in_ready = 1'b1; bus.is_last = 1'b1; bus.byte_num = 2'd1;
    @(negedge clk);
    bus.in_ready = 1'b0; bus.is_last = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (bus.buffer_full !== 1'b0) begin errors++; $display("FAIL pad_not_full: got %b expected 0", bus.buffer_full); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.out !== '0) begin errors++; $display("FAIL midpad_reset_out: got %h expected 0", bus.out); end
    checks++;
    if (bus.buffer_full !== 1'b0 || bus.last_block !== 1'b0)
      begin errors++; $display("FAIL midpad_reset_flags: got full=%b last=%b expected 0 0", bus.buffer_full, bus.last_block); end
    @(negedge clk);
    reset = 1'b0;
    fill_random(13);
    run_message(1'b1);
  endtask

  initial begin
    test_reset();
    test_empty();
    test_full_last_word();
    test_back_to_back();
    test_domain();
    test_random();
    test_reset_mid_pad();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shake_block_padder.md
# shake_block_padder

Sequential message padder for the Keccak/SHAKE core. It accepts the message as a stream of 32-bit big-endian words and assembles them into full rate-sized blocks. After the last partial word it applies multi-rate padding: the domain byte follows the final message byte, zero words fill the rest of the block, and 0x80 is ORed into the final byte. It sits between the message source and the Keccak-f permutation, and presents one rate block at a time until the permutation acknowledges it.

## Interface
- RATE_WORDS, 42, rate in 32-bit words (42 = 1344-bit SHAKE128 rate; 34 = SHAKE256).
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in  in  32  message word, big-endian byte order (byte 0 = in[31:24]).
- in_ready  in  1  `in` valid this cycle.
- is_last  in  1  qualifies `in` as the final, partial word; valid only with in_ready.
- byte_num  in  2  number of valid message bytes in the last word (0..3).
- buffer_full  out  1  block complete; upstream must hold the word.
- out  out  32*RATE_WORDS  assembled block; the first word received is in the MSBs.
- out_ready  out  1  `out` holds a complete block (equals buffer_full).
- last_block  out  1  the current complete block carries the padding.
- f_ack  in  1  permutation has absorbed `out`; single-cycle pulse.

## Operation
- State: shift buffer `out`, word counter `cnt` (0..RATE_WORDS), phase register.
- Phases:
  - IDLE/ABSORB: accepting input.
  - PAD: generating zero words internally.
  - FULL_LAST: final block is held.
- Accept condition: `in_ready & ~buffer_full & phase==ABSORB`.
  - On accept, `out <= {out[32*RATE_WORDS-33:0], w}` and `cnt++`.
- Normal word (is_last=0): `w = in`.
- Last word (is_last=1): `w = pad_word(in, byte_num)`:
  - byte_num=0: D000_0000 pattern, i.e. {D, 24'h0}.
  - byte_num=1: {in[31:24], D, 16'h0}.
  - byte_num=2: {in[31:16], D, 8'h0}.
  - byte_num=3: {in[31:8], D}.
  - D is the domain byte: 0x1F by default.
  - If the last word lands in slot RATE_WORDS-1, `w[7:0] |= 8'h80`. Example: byte_num=3 with D=0x1F gives a final byte of 0x9F.
  - Transition to PAD. If the block is now full, go straight to FULL_LAST.
- PAD: shifts one word per cycle with in_ready ignored.
  - Word value is 32'h0, except the word landing in slot RATE_WORDS-1, which is 32'h00000080.
  - When cnt reaches RATE_WORDS, go to FULL_LAST.
- A whole extra padding block is never required: the last word always has at least one free byte.
- buffer_full = (cnt == RATE_WORDS). last_block = (phase == FULL_LAST).
- f_ack while buffer_full:
  - `cnt <= 0`.
  - If the phase is FULL_LAST, the next phase is ABSORB, ready for a new message.
  - `out` content is not cleared.
- f_ack while not full: ignored.
- in_ready while full or in PAD: ignored, not consumed; upstream holds the word.

## Timing
- Reset values: out=0, cnt=0, buffer_full=0, out_ready=0, last_block=0, phase=ABSORB.
- Throughput: one word per cycle.
- Latency: out_ready rises the cycle after the word filling slot RATE_WORDS-1 is registered, whether that word came from input or from PAD.
- PAD length: RATE_WORDS-cnt-1 cycles after the last word is accepted.
- f_ack and in_ready in the same cycle while full: no accept that cycle; the word is accepted on the next cycle into slot 0.
- is_last with in_ready=0: ignored.
- Reset asserted in any phase, including mid-PAD or FULL_LAST: all outputs go to reset values asynchronously; the partial message is discarded.

## Configuration
- KECCAK_PAD_SHA3_EN:
  - Defined: domain byte D = 0x06 (SHA3-256/512 padding).
  - Undefined: D = 0x1F (SHAKE padding).
- Only the constant changes; the 0x80 final-bit handling is identical in both variants.

## Structure
- Shared package:
  - Domain-byte constant, selected by the macro.
  - Final-bit constant 8'h80.
  - Phase enum (ABSORB, PAD, FULL_LAST).
  - Default RATE_WORDS constants for SHAKE128/SHAKE256.
- One natural combinational sub-module: `keccak_pad_word` (in, byte_num, D → padded word).
- The counter, phase FSM and shift buffer stay in the top.

## Test plan
All scenarios use RATE_WORDS=42 unless stated.
- Empty message (is_last=1, byte_num=0 on the first accept):
  - out_ready goes high 42 cycles later.
  - out word0 = 0x1F000000, words 1..40 = 0, word41 = 0x00000080, last_block=1.
- 41 full words, then in=0x11223344, is_last=1, byte_num=3:
  - word41 = 0x1122339F.
  - out_ready the next cycle, with no PAD cycles.
- 42 full words with no last:
  - out_ready=1, last_block=0.
  - Held in_ready is not consumed.
  - f_ack together with in_ready: the word is accepted the following cycle as word0 of block 2.
- Block 2 from the previous scenario ends with in=0xAABBCCDD, is_last=1, byte_num=2 at slot 0:
  - word0 = 0xAABB1F00, word41 = 0x00000080.
  - After f_ack, phase returns to ABSORB.
- Reset pulsed mid-PAD:
  - out=0, buffer_full=0 immediately.
  - A new message is accepted starting at slot 0.
- With KECCAK_PAD_SHA3_EN, in=0xAA000000, is_last=1, byte_num=1: word = 0xAA060000.
